alu_md: RTL and testbench

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_md.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// alu_md: RV integer ALU with an iterative shift-add multiplier and a restoring radix-2 divider.
// Define ALU_MD_DIV_EN to build the divider (DIV/DIVU/REM/REMU); without it those ops report illegal.
module alu_md #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);
  localparam int unsigned SW        = $clog2(XLEN);
  localparam int unsigned CW        = $clog2(XLEN);
  localparam int unsigned MUL_ITERS = XLEN / MUL_BITS;
  localparam int unsigned PW        = 2 * XLEN;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_OR     = 5'd2;
  localparam logic [4:0] OP_AND    = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLT    = 5'd5;
  localparam logic [4:0] OP_SLTU   = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_REM    = 5'd16;

`ifdef ALU_MD_DIV_EN
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REMU   = 5'd17;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;
  // Iteration registers are shared: MUL uses acc/mcand/mplier as product, multiplicand, multiplier;
  // DIV keeps the remainder in acc low half, divisor in mcand low half, dividend/quotient in mplier.
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            hi_q, hi_d;

  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic            is_mul, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [PW-1:0]   mul_sum, mul_prod;

  assign shamt    = i_b[SW-1:0];
  assign is_mul   = (i_op >= OP_MUL) && (i_op <= OP_MULHU);
  assign a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
  assign a_neg    = a_signed && i_a[XLEN-1];
  assign b_neg    = b_signed && i_b[XLEN-1];
  assign a_mag    = a_neg ? -i_a : i_a;
  assign b_mag    = b_neg ? -i_b : i_b;

  // Single-cycle integer ops
  always_comb begin
    alu_res = '0;
    case (i_op)
      OP_ADD:  alu_res = i_a + i_b;
      OP_SUB:  alu_res = i_a - i_b;
      OP_OR:   alu_res = i_a | i_b;
      OP_AND:  alu_res = i_a & i_b;
      OP_XOR:  alu_res = i_a ^ i_b;
      OP_SLT:  alu_res = XLEN'($signed(i_a) < $signed(i_b));
      OP_SLTU: alu_res = XLEN'(i_a < i_b);
      OP_SLL:  alu_res = i_a << shamt;
      OP_SRL:  alu_res = i_a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(i_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One multiplier step: add multiplicand times the low MUL_BITS of the multiplier
  always_comb begin
    mul_sum = acc_q;
    for (int unsigned j = 0; j < MUL_BITS; j++) begin
      if (mplier_q[j]) mul_sum = mul_sum + (mcand_q << j);
    end
  end

  assign mul_prod = neg_q ? -mul_sum : mul_sum;

`ifdef ALU_MD_DIV_EN
  logic            is_div, is_quo, div_ge;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_nx, quo_nx, div_val;

  assign is_div  = (i_op >= OP_DIV) && (i_op <= OP_REMU);
  assign is_quo  = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign rem_sh  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
  assign div_ge  = rem_sh >= {1'b0, mcand_q[XLEN-1:0]};
  assign rem_nx  = div_ge ? XLEN'(rem_sh - {1'b0, mcand_q[XLEN-1:0]}) : rem_sh[XLEN-1:0];
  assign quo_nx  = {mplier_q[XLEN-2:0], div_ge};
  assign div_val = hi_q ? rem_nx : quo_nx;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    case (state_q)
      IDLE: begin
        if (i_valid && !i_kill) begin
          state_d   = DONE;
          illegal_d = 1'b0;
          cnt_d     = '0;
          acc_d     = '0;
          if (i_op <= OP_SRA) begin
            result_d = alu_res;
          end else if (is_mul) begin
            state_d  = MUL;
            mcand_d  = PW'(a_mag);
            mplier_d = b_mag;
            neg_d    = a_neg ^ b_neg;
            hi_d     = (i_op != OP_MUL);
          end
`ifdef ALU_MD_DIV_EN
          else if (is_div) begin
            if (i_b == '0) begin
              result_d = is_quo ? '1 : i_a;
            end else if (a_signed && (i_a == MIN_NEG) && (i_b == '1)) begin
              result_d = is_quo ? i_a : '0;
            end else begin
              state_d  = DIV;
              mcand_d  = PW'(b_mag);
              mplier_d = a_mag;
              hi_d     = !is_quo;
              neg_d    = is_quo ? (a_neg ^ b_neg) : a_neg;
            end
          end
`endif
          else begin
            result_d  = '0;
            illegal_d = 1'b1;
          end
        end
      end
      MUL: begin
        if (i_kill) begin
          state_d = IDLE;
        end else begin
          acc_d    = mul_sum;
          mcand_d  = mcand_q << MUL_BITS;
          mplier_d = mplier_q >> MUL_BITS;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(MUL_ITERS - 1)) begin
            state_d  = DONE;
            result_d = hi_q ? mul_prod[PW-1:XLEN] : mul_prod[XLEN-1:0];
          end
        end
      end
`ifdef ALU_MD_DIV_EN
      DIV: begin
        if (i_kill) begin
          state_d = IDLE;
        end else begin
          acc_d    = PW'(rem_nx);
          mplier_d = quo_nx;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_d  = DONE;
            result_d = neg_q ? -div_val : div_val;
          end
        end
      end
`endif
      DONE: begin
        if (i_kill || i_ready) begin
          state_d   = IDLE;
          illegal_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      hi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      hi_q      <= hi_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_valid   = (state_q == DONE);
  assign o_result  = result_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed vector table plus hand sequences for backpressure, kill and async reset.
module tb_alu_md;
  localparam int unsigned XLEN = 32;

  logic            clk, rst, i_valid, i_kill, i_ready;
  logic [4:0]      i_op;
  logic [XLEN-1:0] i_a, i_b;
  logic            o_ready, o_valid, o_illegal;
  logic [XLEN-1:0] o_result;
  logic            o_ready4, o_valid4, o_illegal4;
  logic [XLEN-1:0] o_result4;

  alu_md #(.XLEN(XLEN), .MUL_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_kill(i_kill), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_illegal(o_illegal)
  );

  alu_md #(.XLEN(XLEN), .MUL_BITS(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready4), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_kill(i_kill), .o_valid(o_valid4), .i_ready(i_ready),
    .o_result(o_result4), .o_illegal(o_illegal4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request with i_ready high; returns result, latency in edges (accept edge = 1) and ready after transfer
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ill, output int lat,
                       output logic [31:0] res4, output int lat4, output logic rdy_after,
                       output logic ill_after);
    @(negedge clk);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    lat = 0; lat4 = 0; res4 = '0;
    while (lat < 200) begin
      @(posedge clk); #1;
      if (lat == 0) begin
        i_valid = 1'b0;
        i_op = 5'($urandom); i_a = $urandom; i_b = $urandom;
      end
      lat++;
      if (o_valid4 && lat4 == 0) begin
        lat4 = lat; res4 = o_result4;
      end
      if (o_valid) break;
    end
    res = o_result; ill = o_illegal;
    @(posedge clk); #1;
    rdy_after = o_ready; ill_after = o_illegal;
  endtask

  initial begin
    logic [31:0] res, res4;
    logic        ill, rdy, ill_a, saw;
    int          lat, lat4;

    vecs.push_back('{5'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1});
    vecs.push_back('{5'd2,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1});
    vecs.push_back('{5'd3,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1});
    vecs.push_back('{5'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1});
    vecs.push_back('{5'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1});
    vecs.push_back('{5'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd7,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1});
    vecs.push_back('{5'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1});
    vecs.push_back('{5'd9,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1});
    vecs.push_back('{5'd10, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33});
    vecs.push_back('{5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33});
    vecs.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
    vecs.push_back('{5'd11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{5'd20, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
`ifdef ALU_MD_DIV_EN
    vecs.push_back('{5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{5'd16, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{5'd15, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back('{5'd16, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1});
    vecs.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1});
    vecs.push_back('{5'd17, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 33});
    vecs.push_back('{5'd15, 32'hFFFF_FFFF, 32'h0000_0003, 32'h5555_5555, 1'b0, 33});
`else
    vecs.push_back('{5'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{5'd17, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 1'b1, 1});
`endif

    rst = 1'b1; i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b1;
    i_op = '0; i_a = '0; i_b = '0;
    #12;
    chk("reset o_ready", 32'(o_ready), 32'd1);
    chk("reset o_valid", 32'(o_valid), 32'd0);
    chk("reset o_result", o_result, 32'd0);
    chk("reset o_illegal", 32'(o_illegal), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    foreach (vecs[k]) begin
      do_op(vecs[k].op, vecs[k].a, vecs[k].b, res, ill, lat, res4, lat4, rdy, ill_a);
      chk($sformatf("v%0d op%0d result", k, vecs[k].op), res, vecs[k].res);
      chk($sformatf("v%0d op%0d illegal", k, vecs[k].op), 32'(ill), 32'(vecs[k].ill));
      chk($sformatf("v%0d op%0d latency", k, vecs[k].op), 32'(lat), 32'(vecs[k].lat));
      chk($sformatf("v%0d op%0d mb4 result", k, vecs[k].op), res4, vecs[k].res);
      chk($sformatf("v%0d ready after transfer", k), 32'(rdy), 32'd1);
      chk($sformatf("v%0d illegal low when idle", k), 32'(ill_a), 32'd0);
    end

    // MUL_BITS=4 latency for MULH
    do_op(5'd11, 32'h8000_0000, 32'h8000_0000, res, ill, lat, res4, lat4, rdy, ill_a);
    chk("mulh mb4 latency", 32'(lat4), 32'd9);
    chk("mulh mb4 result", res4, 32'h4000_0000);

    // Backpressure: result held while i_ready low
    i_ready = 1'b0;
    @(negedge clk);
    i_op = 5'd0; i_a = 32'd2; i_b = 32'd3; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom;
    chk("bp valid", 32'(o_valid), 32'd1);
    chk("bp result", o_result, 32'd5);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold result c%0d", c), o_result, 32'd5);
      chk($sformatf("bp ready low c%0d", c), 32'(o_ready), 32'd0);
      chk($sformatf("bp valid held c%0d", c), 32'(o_valid), 32'd1);
    end
    @(negedge clk); i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", 32'(o_valid), 32'd0);
    chk("bp release ready", 32'(o_ready), 32'd1);

    // Kill during MUL iteration 10
    @(negedge clk);
    i_op = 5'd10; i_a = 32'd3; i_b = 32'd5; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; i_kill = 1'b1;
    @(posedge clk); #1;
    i_kill = 1'b0;
    chk("kill mul ready", 32'(o_ready), 32'd1);
    chk("kill mul valid", 32'(o_valid), 32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) saw = 1'b1;
    end
    chk("kill mul no result", 32'(saw), 32'd0);
    do_op(5'd0, 32'd2, 32'd3, res, ill, lat, res4, lat4, rdy, ill_a);
    chk("after kill add", res, 32'd5);
    chk("after kill add latency", 32'(lat), 32'd1);

    // Kill in IDLE blocks acceptance
    @(negedge clk);
    i_op = 5'd0; i_a = 32'd1; i_b = 32'd1; i_valid = 1'b1; i_kill = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_kill = 1'b0;
    chk("kill idle ready", 32'(o_ready), 32'd1);
    chk("kill idle valid", 32'(o_valid), 32'd0);

    // Kill in DONE drops the result without i_ready
    i_ready = 1'b0;
    @(negedge clk);
    i_op = 5'd20; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("done illegal", 32'(o_illegal), 32'd1);
    i_kill = 1'b1;
    @(posedge clk); #1;
    i_kill = 1'b0; i_ready = 1'b1;
    chk("kill done valid", 32'(o_valid), 32'd0);
    chk("kill done illegal", 32'(o_illegal), 32'd0);
    chk("kill done ready", 32'(o_ready), 32'd1);

    // Asynchronous reset mid-operation
    @(negedge clk);
`ifdef ALU_MD_DIV_EN
    i_op = 5'd15;
`else
    i_op = 5'd10;
`endif
    i_a = 32'd100; i_b = 32'd7; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("async rst valid", 32'(o_valid), 32'd0);
    chk("async rst result", o_result, 32'd0);
    chk("async rst ready", 32'(o_ready), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    do_op(5'd0, 32'd4, 32'd5, res, ill, lat, res4, lat4, rdy, ill_a);
    chk("post rst add", res, 32'd9);
    chk("post rst add latency", 32'(lat), 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_valid) saw = 1'b1;
    end
    chk("post rst no stale", 32'(saw), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
